// File: rtl/checkpoint_monitor.sv
// On-chip checkpoint monitor: filters a firmware-driven status code, tracks
// start/milestone/end markers and a programmable timeout, reports sticky results.
module checkpoint_monitor #(
  parameter int                 WIDTH         = 16,
  parameter logic [WIDTH-1:0]   START_CODE    = 16'hAB60,
  parameter logic [WIDTH-1:0]   END_MASK      = 16'hFFFC,
  parameter logic [WIDTH-1:0]   END_CODE      = 16'hFFF4,
  parameter int                 PASS_BIT      = 1,
  parameter int                 STABLE_CYCLES = 2,
  parameter int                 TO_W          = 32,
  parameter int                 CNT_W         = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             enable,
  input  logic [TO_W-1:0]  timeout_limit,
  input  logic [WIDTH-1:0] code_in,
  output logic             busy,
  output logic             started,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             irq,
  output logic [CNT_W-1:0] milestone_cnt,
  output logic [WIDTH-1:0] last_code,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_RUN        = 3'd2,
    ST_PASS       = 3'd3,
    ST_FAIL       = 3'd4,
    ST_TIMEOUT    = 3'd5
  } state_t;

  localparam int              RL_W     = $clog2(STABLE_CYCLES + 1);
  localparam logic [RL_W-1:0] STABLE_L = RL_W'(STABLE_CYCLES);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] code_s;
  logic [RL_W-1:0]  run_len;
  logic [RL_W-1:0]  run_len_inc;
  logic             qual;
  logic [TO_W-1:0]  to_cnt;
  logic             is_end;
  logic             to_hit;
  logic             term_q;
  logic             term_d;

  assign run_len_inc = run_len + 1'b1;

  // qual fires once, on the cycle the run length first reaches the stability threshold
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      code_s  <= '0;
      run_len <= '0;
      qual    <= 1'b0;
    end else begin
      code_s <= code_in;
      if (code_in != code_s) begin
        run_len <= RL_W'(1);
        qual    <= (STABLE_L == RL_W'(1));
      end else if (run_len != STABLE_L) begin
        run_len <= run_len_inc;
        qual    <= (run_len_inc == STABLE_L);
      end else begin
        qual    <= 1'b0;
      end
    end
  end

  assign is_end = ((code_s & END_MASK) == END_CODE);
  assign to_hit = (timeout_limit != '0) && (to_cnt >= (timeout_limit - TO_W'(1)));
  assign term_q = (state_q == ST_PASS) || (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
  assign term_d = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);

  // An end event takes priority over a timeout landing on the same cycle
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:       state_d = ST_WAIT_START;
        ST_WAIT_START: begin
          if (qual && (code_s == START_CODE)) state_d = ST_RUN;
          else if (to_hit)                    state_d = ST_TIMEOUT;
        end
        ST_RUN: begin
          if (qual && is_end)  state_d = code_s[PASS_BIT] ? ST_PASS : ST_FAIL;
          else if (to_hit)     state_d = ST_TIMEOUT;
        end
        default:       state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= ST_IDLE;
      irq           <= 1'b0;
      to_cnt        <= '0;
      milestone_cnt <= '0;
      last_code     <= '0;
      started       <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state_q <= state_d;
      irq     <= term_d && !term_q;
      if ((state_q != ST_IDLE) && qual) last_code <= code_s;
      // Disarming or idling wipes the run; terminal states leave the counters frozen
      if (!enable || (state_q == ST_IDLE)) begin
        to_cnt        <= '0;
        milestone_cnt <= '0;
        started       <= 1'b0;
        done          <= 1'b0;
        pass          <= 1'b0;
        fail          <= 1'b0;
        timeout       <= 1'b0;
      end else begin
        if (((state_q == ST_WAIT_START) || (state_q == ST_RUN)) && (to_cnt != '1))
          to_cnt <= to_cnt + 1'b1;
        if ((state_q == ST_RUN) && qual && !is_end && (milestone_cnt != '1))
          milestone_cnt <= milestone_cnt + 1'b1;
        if (state_d == ST_RUN)     started <= 1'b1;
        if (state_d == ST_PASS)    begin pass <= 1'b1; done <= 1'b1; end
        if (state_d == ST_FAIL)    begin fail <= 1'b1; done <= 1'b1; end
        if (state_d == ST_TIMEOUT) timeout <= 1'b1;
      end
    end
  end

  assign busy  = (state_q == ST_WAIT_START) || (state_q == ST_RUN);
  assign state = state_q;

endmodule

// File: tb/tb_checkpoint_monitor.sv
// Directed self-checking bench for checkpoint_monitor with default parameters.
module tb_checkpoint_monitor;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] timeout_limit = '0;
  logic [15:0] code_in = '0;
  logic        busy, started, done, pass, fail, timeout, irq;
  logic [7:0]  milestone_cnt;
  logic [15:0] last_code;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;
  int irq_count = 0;
  int irq_base;

  checkpoint_monitor dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .enable        (enable),
    .timeout_limit (timeout_limit),
    .code_in       (code_in),
    .busy          (busy),
    .started       (started),
    .done          (done),
    .pass          (pass),
    .fail          (fail),
    .timeout       (timeout),
    .irq           (irq),
    .milestone_cnt (milestone_cnt),
    .last_code     (last_code),
    .state         (state)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(negedge wb_clk_i) if (irq === 1'b1) irq_count++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1; enable = 1'b0; code_in = '0; timeout_limit = '0;
    tick(2);
    wb_rst_i = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1; enable = 1'b1; code_in = 16'hAB60;
    tick(2);
    checks++;
    if ({busy, started, done, pass, fail, timeout, irq} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 0000000",
                         {busy, started, done, pass, fail, timeout, irq});
    end
    checks++;
    if (state !== 3'd0 || milestone_cnt !== 8'd0 || last_code !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_regs: got state=%0d cnt=%0d last=%h expected 0/0/0000",
                         state, milestone_cnt, last_code);
    end
    do_reset();
  endtask

  task automatic test_nominal_pass();
    do_reset();
    irq_base = irq_count;
    enable = 1'b1;
    tick(1);
    checks++;
    if (state !== 3'd1 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL nominal_arm: got state=%0d busy=%b expected 1/1", state, busy);
    end
    code_in = 16'hAB60;
    tick(2);
    checks++;
    if (started !== 1'b0) begin
      errors++; $display("[TB] FAIL nominal_start_early: got started=%b expected 0", started);
    end
    tick(1);
    checks++;
    if (started !== 1'b1 || state !== 3'd2) begin
      errors++; $display("[TB] FAIL nominal_start: got started=%b state=%0d expected 1/2", started, state);
    end
    tick(1);
    code_in = 16'h1234;
    tick(4);
    code_in = 16'hFFF6;
    tick(2);
    checks++;
    if (pass !== 1'b0 || state !== 3'd2) begin
      errors++; $display("[TB] FAIL nominal_pass_early: got pass=%b state=%0d expected 0/2", pass, state);
    end
    tick(1);
    checks++;
    if (pass !== 1'b1 || done !== 1'b1 || fail !== 1'b0 || state !== 3'd3 || irq !== 1'b1) begin
      errors++; $display("[TB] FAIL nominal_pass: got pass=%b done=%b fail=%b state=%0d irq=%b expected 1/1/0/3/1",
                         pass, done, fail, state, irq);
    end
    checks++;
    if (milestone_cnt !== 8'd1 || last_code !== 16'hFFF6 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL nominal_regs: got cnt=%0d last=%h busy=%b expected 1/fff6/0",
                         milestone_cnt, last_code, busy);
    end
    tick(4);
    checks++;
    if (irq_count - irq_base !== 1 || state !== 3'd3) begin
      errors++; $display("[TB] FAIL nominal_irq_once: got pulses=%0d state=%0d expected 1/3",
                         irq_count - irq_base, state);
    end
  endtask

  task automatic test_fail_path();
    do_reset();
    irq_base = irq_count;
    enable = 1'b1;
    tick(1);
    code_in = 16'hAB60;
    tick(3);
    code_in = 16'hFFF4;
    tick(3);
    checks++;
    if (fail !== 1'b1 || pass !== 1'b0 || done !== 1'b1 || state !== 3'd4) begin
      errors++; $display("[TB] FAIL fail_path: got fail=%b pass=%b done=%b state=%0d expected 1/0/1/4",
                         fail, pass, done, state);
    end
    checks++;
    if (milestone_cnt !== 8'd0 || last_code !== 16'hFFF4) begin
      errors++; $display("[TB] FAIL fail_regs: got cnt=%0d last=%h expected 0/fff4", milestone_cnt, last_code);
    end
    tick(3);
    checks++;
    if (irq_count - irq_base !== 1) begin
      errors++; $display("[TB] FAIL fail_irq_once: got %0d expected 1", irq_count - irq_base);
    end
  endtask

  task automatic test_glitch_filter();
    do_reset();
    enable = 1'b1;
    tick(1);
    code_in = 16'hAB60;
    tick(1);
    code_in = 16'h0000;
    tick(1);
    code_in = 16'hFFF6;
    tick(6);
    checks++;
    if (started !== 1'b0 || state !== 3'd1 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL glitch_ignored: got started=%b state=%0d done=%b expected 0/1/0",
                         started, state, done);
    end
    checks++;
    if (last_code !== 16'hFFF6) begin
      errors++; $display("[TB] FAIL glitch_last_code: got %h expected fff6", last_code);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    irq_base = irq_count;
    timeout_limit = 32'd100;
    enable = 1'b1;
    code_in = 16'hAB60;
    tick(1);
    tick(99);
    checks++;
    if (state !== 3'd2 || timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_early: got state=%0d timeout=%b expected 2/0", state, timeout);
    end
    tick(1);
    checks++;
    if (state !== 3'd5 || timeout !== 1'b1 || done !== 1'b0 || irq !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_fire: got state=%0d timeout=%b done=%b irq=%b busy=%b expected 5/1/0/1/0",
                         state, timeout, done, irq, busy);
    end
    tick(3);
    checks++;
    if (irq_count - irq_base !== 1 || state !== 3'd5) begin
      errors++; $display("[TB] FAIL timeout_irq_once: got pulses=%0d state=%0d expected 1/5",
                         irq_count - irq_base, state);
    end
  endtask

  task automatic test_end_vs_timeout();
    do_reset();
    timeout_limit = 32'd100;
    enable = 1'b1;
    code_in = 16'hAB60;
    tick(1);
    tick(97);
    code_in = 16'hFFF6;
    tick(2);
    checks++;
    if (state !== 3'd2) begin
      errors++; $display("[TB] FAIL race_early: got state=%0d expected 2", state);
    end
    tick(1);
    checks++;
    if (pass !== 1'b1 || timeout !== 1'b0 || state !== 3'd3) begin
      errors++; $display("[TB] FAIL race_end_wins: got pass=%b timeout=%b state=%0d expected 1/0/3",
                         pass, timeout, state);
    end
  endtask

  task automatic test_limit_lowered();
    do_reset();
    enable = 1'b1;
    code_in = 16'hAB60;
    tick(21);
    checks++;
    if (state !== 3'd2) begin
      errors++; $display("[TB] FAIL lower_no_limit: got state=%0d expected 2", state);
    end
    timeout_limit = 32'd5;
    tick(1);
    checks++;
    if (state !== 3'd5 || timeout !== 1'b1) begin
      errors++; $display("[TB] FAIL lower_fire: got state=%0d timeout=%b expected 5/1", state, timeout);
    end
  endtask

  task automatic test_abort_rearm();
    do_reset();
    enable = 1'b1;
    tick(1);
    code_in = 16'hAB60;
    tick(3);
    for (int i = 1; i <= 5; i++) begin
      code_in = 16'(i);
      tick(3);
    end
    checks++;
    if (milestone_cnt !== 8'd5 || state !== 3'd2) begin
      errors++; $display("[TB] FAIL abort_setup: got cnt=%0d state=%0d expected 5/2", milestone_cnt, state);
    end
    irq_base = irq_count;
    enable = 1'b0;
    tick(1);
    checks++;
    if (state !== 3'd0 || started !== 1'b0 || milestone_cnt !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_idle: got state=%0d started=%b cnt=%0d busy=%b expected 0/0/0/0",
                         state, started, milestone_cnt, busy);
    end
    enable = 1'b1;
    tick(1);
    checks++;
    if (state !== 3'd1 || {started, done, pass, fail, timeout} !== 5'b0 || milestone_cnt !== 8'd0) begin
      errors++; $display("[TB] FAIL abort_rearm: got state=%0d flags=%b cnt=%0d expected 1/00000/0",
                         state, {started, done, pass, fail, timeout}, milestone_cnt);
    end
    tick(2);
    checks++;
    if (irq_count - irq_base !== 0) begin
      errors++; $display("[TB] FAIL abort_no_irq: got %0d expected 0", irq_count - irq_base);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    enable = 1'b1;
    tick(1);
    code_in = 16'hAB60;
    tick(3);
    code_in = 16'h0042;
    tick(3);
    checks++;
    if (state !== 3'd2 || milestone_cnt !== 8'd1 || last_code !== 16'h0042) begin
      errors++; $display("[TB] FAIL midrun_setup: got state=%0d cnt=%0d last=%h expected 2/1/0042",
                         state, milestone_cnt, last_code);
    end
    wb_rst_i = 1'b1;
    tick(1);
    checks++;
    if (state !== 3'd0 || {busy, started, done, pass, fail, timeout, irq} !== 7'b0 ||
        milestone_cnt !== 8'd0 || last_code !== 16'd0) begin
      errors++; $display("[TB] FAIL midrun_reset: got state=%0d flags=%b cnt=%0d last=%h expected 0/0000000/0/0000",
                         state, {busy, started, done, pass, fail, timeout, irq}, milestone_cnt, last_code);
    end
    wb_rst_i = 1'b0;
    tick(1);
    checks++;
    if (state !== 3'd1) begin
      errors++; $display("[TB] FAIL midrun_rearm: got state=%0d expected 1", state);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal_pass();
    test_fail_path();
    test_glitch_filter();
    test_timeout();
    test_end_vs_timeout();
    test_limit_lowered();
    test_abort_rearm();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/checkpoint_monitor.md
Name: checkpoint_monitor

Overview:
- Synthesizable on-chip monitor for the user project; the parametrised successor to the bench-side checkpoint watcher.
- Watches a status code word driven by firmware onto user I/O, e.g. mprj_io[31:16].
- Detects a start marker, counts intermediate milestones, detects a masked end marker carrying a pass flag, and enforces a programmable timeout.
- Reports pass/fail/timeout with sticky flags and a one-cycle irq, so self-test runs without an external bench.

Parameters:
- WIDTH, 16, width of the monitored code word.
- START_CODE, 16'hAB60, exact code that starts a run.
- END_MASK, 16'hFFFC, mask applied to the code before the end compare.
- END_CODE, 16'hFFF4, masked value that ends a run.
- PASS_BIT, 1, bit index of the end code that carries the pass/fail flag.
- STABLE_CYCLES, 2, consecutive cycles a code must hold before it qualifies (>=1).
- TO_W, 32, width of the timeout counter and limit.
- CNT_W, 8, width of the milestone counter.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- enable  in  1  arms the monitor; low forces IDLE and clears status.
- timeout_limit  in  TO_W  cycle limit; 0 disables the timeout.
- code_in  in  WIDTH  monitored code word (asynchronous to firmware, sampled here).
- busy  out  1  high in WAIT_START or RUN.
- started  out  1  sticky; start marker seen.
- done  out  1  sticky; PASS or FAIL reached.
- pass  out  1  sticky.
- fail  out  1  sticky.
- timeout  out  1  sticky.
- irq  out  1  one-cycle pulse on entry to any terminal state.
- milestone_cnt  out  CNT_W  qualified codes seen in RUN, saturating.
- last_code  out  WIDTH  most recent qualified code.
- state  out  3  FSM encoding: IDLE=0, WAIT_START=1, RUN=2, PASS=3, FAIL=4, TIMEOUT=5.

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers 0. Reset has priority over every other event.
- Sampling and qualification:
  - code_s <= code_in every cycle.
  - run_len resets to 1 when code_s changes; otherwise it increments, saturating at STABLE_CYCLES.
  - qual pulses for exactly one cycle when run_len first reaches STABLE_CYCLES.
  - Latency from a code_in change to an FSM/output response is STABLE_CYCLES+1 cycles.
- last_code: loads code_s on every qual, in any non-IDLE state.
- IDLE:
  - enable=1 -> WAIT_START next cycle.
  - Clears the timeout counter, milestone_cnt and the sticky flags.
- WAIT_START:
  - qual with code_s==START_CODE -> RUN; started=1.
  - Any other qualified code, including an end code, is ignored.
- RUN, on qual:
  - (code_s & END_MASK)==END_CODE -> PASS if code_s[PASS_BIT]==1, else FAIL.
  - Any other code, including a repeated START_CODE, increments milestone_cnt (saturating at all-ones).
- Timeout:
  - Counter increments every cycle in WAIT_START and RUN.
  - When timeout_limit!=0 and the counter reaches timeout_limit-1 without an end event -> TIMEOUT.
  - timeout_limit=N therefore allows exactly N cycles after leaving IDLE.
  - An end qual and the timeout in the same cycle: the end event wins.
  - timeout_limit is read live; lowering it below the current count fires the timeout on the next cycle.
- Terminal states PASS/FAIL/TIMEOUT:
  - Set the matching sticky flag; done=1 for PASS/FAIL only.
  - irq=1 on the entry cycle only.
  - busy=0; the counter and milestone_cnt freeze.
  - State holds until enable=0.
- enable=0 in any state -> IDLE next cycle, all sticky flags and counters cleared. A mid-run abort generates no irq.
- Counters never wrap. The timeout counter saturates at all-ones.

Test Plan:
- Nominal pass (STABLE_CYCLES=2, limit=0):
  - Stimulus: enable=1, code_in 16'hAB60 for 4 cycles, 16'h1234 for 4 cycles, then 16'hFFF6.
  - Required: started 3 cycles after the AB60 edge; pass=1, done=1, state=3 and a single irq pulse 3 cycles after the FFF6 edge; milestone_cnt=1; last_code=16'hFFF6.
- Fail path:
  - Stimulus: AB60, then 16'hFFF4.
  - Required: fail=1, pass=0, done=1, state=4, irq pulses once.
- Glitch filter:
  - Stimulus: AB60 held 1 cycle between 0000 values, then FFF6 held.
  - Required: started stays 0, state stays 1, last_code=16'hFFF6 (the end code is ignored before start).
- Timeout:
  - Stimulus: limit=100, AB60 held, no end code.
  - Required: timeout=1 and state=5 exactly 100 cycles after leaving IDLE; irq pulses once; done=0.
  - With the end qual landing on cycle 100: pass=1, timeout=0.
- Abort and re-arm:
  - Stimulus: in RUN, milestone_cnt=5, drop enable for 1 cycle, raise it again.
  - Required: state 0 then 1; all flags and counts 0; no irq.
- Reset mid-run:
  - Stimulus: assert wb_rst_i for 1 cycle in RUN with enable=1.
  - Required: all outputs 0 on the next edge; state returns to 1 on the following cycle.
